cfs_algn_core: RTL and testbench



---
 rtl/cfs_algn_pkg.sv | 47 ++++
 rtl/cfs_algn_core_if.sv | 15 +
 rtl/cfs_algn_byte_buf.sv | 71 +++++++
 rtl/cfs_algn_core.sv | 68 ++++++
 tb/tb_cfs_algn_core.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cfs_algn_pkg.sv
// Shared width helpers and FIFO field positions for the aligner blocks.
// FIFO entry layout: {size, offset, data} with data in the LSBs.
package cfs_algn_pkg;

   localparam int unsigned ALGN_DATA_LSB = 0;

   function automatic int unsigned algn_bytes(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned algn_offset_width(input int unsigned dw);
      return (dw <= 8) ? 1 : $clog2(dw / 8);
   endfunction

   function automatic int unsigned algn_size_width(input int unsigned dw);
      return $clog2(dw / 8) + 1;
   endfunction

   function automatic int unsigned algn_fifo_width(input int unsigned dw);
      return dw + algn_offset_width(dw) + algn_size_width(dw);
   endfunction

   function automatic int unsigned algn_cnt_width(input int unsigned dw);
      return $clog2(2 * (dw / 8)) + 1;
   endfunction

   function automatic int unsigned algn_data_msb(input int unsigned dw);
      return dw - 1;
   endfunction

   function automatic int unsigned algn_offset_lsb(input int unsigned dw);
      return dw;
   endfunction

   function automatic int unsigned algn_offset_msb(input int unsigned dw);
      return dw + algn_offset_width(dw) - 1;
   endfunction

   function automatic int unsigned algn_size_lsb(input int unsigned dw);
      return dw + algn_offset_width(dw);
   endfunction

   function automatic int unsigned algn_size_msb(input int unsigned dw);
      return algn_fifo_width(dw) - 1;
   endfunction

endpackage

// File: rtl/cfs_algn_core_if.sv
// Valid/ready stream carrying one aligner FIFO entry per transfer.
interface cfs_algn_core_if
   import cfs_algn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = algn_fifo_width(32)
) ();

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/cfs_algn_byte_buf.sv
// Byte accumulator: shift-down on consume, append-at-fill-level on produce.
// Bytes above the fill level are kept zero so appends can simply be OR-ed in.
module cfs_algn_byte_buf
   import cfs_algn_pkg::*;
#(
   parameter int unsigned  ALGN_DATA_WIDTH = 32,
   localparam int unsigned OW = algn_offset_width(ALGN_DATA_WIDTH),
   localparam int unsigned SW = algn_size_width(ALGN_DATA_WIDTH),
   localparam int unsigned CW = algn_cnt_width(ALGN_DATA_WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       shift_en,
   input  logic [SW-1:0]              shift_size,
   input  logic                       app_en,
   input  logic [SW-1:0]              app_size,
   input  logic [OW-1:0]              app_offset,
   input  logic [ALGN_DATA_WIDTH-1:0] app_data,
   output logic [ALGN_DATA_WIDTH-1:0] acc_lo,
   output logic [CW-1:0]              cnt
);

   localparam int unsigned AW = 2 * ALGN_DATA_WIDTH;

   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_sh;
   logic [AW-1:0] app_raw;
   logic [AW-1:0] app_bytes;
   logic [CW-1:0] cnt_sh;

   always_comb begin
      acc_sh = acc_q;
      cnt_sh = cnt_q;
      if (shift_en) begin
         acc_sh = acc_q >> {shift_size, 3'b000};
         cnt_sh = cnt_q - CW'(shift_size);
      end

      // Drop lanes below the entry offset, then keep only its valid bytes.
      app_raw   = {{ALGN_DATA_WIDTH{1'b0}}, app_data} >> {app_offset, 3'b000};
      app_bytes = app_raw & ~({AW{1'b1}} << {app_size, 3'b000});

      acc_d = acc_sh;
      cnt_d = cnt_sh;
      if (app_en) begin
         acc_d = acc_sh | (app_bytes << {cnt_sh, 3'b000});
         cnt_d = cnt_sh + CW'(app_size);
      end

      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_lo = acc_q[ALGN_DATA_WIDTH-1:0];
   assign cnt    = cnt_q;

endmodule

// File: rtl/cfs_algn_core.sv
// Aligner re-alignment stage: gathers valid bytes from RX entries and emits
// chunks shaped by ctrl_size/ctrl_offset. Handshakes depend only on state (and clr).
module cfs_algn_core
   import cfs_algn_pkg::*;
#(
   parameter int unsigned  ALGN_DATA_WIDTH = 32,
   localparam int unsigned B  = algn_bytes(ALGN_DATA_WIDTH),
   localparam int unsigned OW = algn_offset_width(ALGN_DATA_WIDTH),
   localparam int unsigned SW = algn_size_width(ALGN_DATA_WIDTH),
   localparam int unsigned CW = algn_cnt_width(ALGN_DATA_WIDTH)
) (
   input  logic               pclk,
   input  logic               preset,
   input  logic [SW-1:0]      ctrl_size,
   input  logic [OW-1:0]      ctrl_offset,
   input  logic               clr,
   cfs_algn_core_if.slave     pop_if,
   cfs_algn_core_if.master    push_if,
   output logic [CW-1:0]      status_cnt_bytes
);

   localparam int unsigned DW       = ALGN_DATA_WIDTH;
   localparam int unsigned OFF_LSB  = algn_offset_lsb(DW);
   localparam int unsigned OFF_MSB  = algn_offset_msb(DW);
   localparam int unsigned SIZE_LSB = algn_size_lsb(DW);
   localparam int unsigned SIZE_MSB = algn_size_msb(DW);

   logic          pop_fire;
   logic          push_fire;
   logic [SW-1:0] ent_size;
   logic [OW-1:0] ent_offset;
   logic [DW-1:0] ent_data;
   logic [DW-1:0] acc_lo;
   logic [DW-1:0] chunk;
   logic [CW-1:0] cnt;

   assign ent_size   = pop_if.data[SIZE_MSB:SIZE_LSB];
   assign ent_offset = pop_if.data[OFF_MSB:OFF_LSB];
   assign ent_data   = pop_if.data[DW-1:ALGN_DATA_LSB];

   always_comb begin
      pop_if.ready  = (cnt <= CW'(B)) && !clr;
      push_if.valid = (cnt >= CW'(ctrl_size));
      pop_fire      = pop_if.valid && pop_if.ready;
      push_fire     = push_if.valid && push_if.ready;
      // Oldest ctrl_size bytes, moved up to the programmed lane offset.
      chunk         = (acc_lo & ~({DW{1'b1}} << {ctrl_size, 3'b000})) << {ctrl_offset, 3'b000};
      push_if.data  = {ctrl_size, ctrl_offset, chunk};
      status_cnt_bytes = cnt;
   end

   cfs_algn_byte_buf #(
      .ALGN_DATA_WIDTH(ALGN_DATA_WIDTH)
   ) u_byte_buf (
      .clk        (pclk),
      .rst        (preset),
      .clr        (clr),
      .shift_en   (push_fire),
      .shift_size (ctrl_size),
      .app_en     (pop_fire),
      .app_size   (ent_size),
      .app_offset (ent_offset),
      .app_data   (ent_data),
      .acc_lo     (acc_lo),
      .cnt        (cnt)
   );

endmodule

// File: tb/tb_cfs_algn_core.sv
// Directed bench for cfs_algn_core (B=4) against a byte-queue model plus literal checks.
module tb_cfs_algn_core;
   import cfs_algn_pkg::*;

   localparam int unsigned DW = 32;
   localparam int          B  = 4;
   localparam int unsigned FW = 37;

   logic       pclk = 1'b0;
   logic       preset = 1'b1;
   logic       clr = 1'b0;
   logic [2:0] ctrl_size = 3'd4;
   logic [1:0] ctrl_offset = 2'd0;
   logic [3:0] status_cnt_bytes;

   cfs_algn_core_if #(.DATA_WIDTH(FW)) pop_if ();
   cfs_algn_core_if #(.DATA_WIDTH(FW)) push_if ();

   cfs_algn_core #(
      .ALGN_DATA_WIDTH(DW)
   ) dut (
      .pclk             (pclk),
      .preset           (preset),
      .ctrl_size        (ctrl_size),
      .ctrl_offset      (ctrl_offset),
      .clr              (clr),
      .pop_if           (pop_if),
      .push_if          (push_if),
      .status_cnt_bytes (status_cnt_bytes)
   );

   always #5 pclk = ~pclk;

   int n_cmp   = 0;
   int n_err   = 0;
   int rst_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] ent(input logic [2:0] s, input logic [1:0] o, input logic [31:0] d);
      return {s, o, d};
   endfunction

   task automatic tick();
      @(negedge pclk);
      #1;
   endtask

   // Model: the accumulator is just an ordered queue of bytes.
   initial begin
      logic [7:0]  q[$];
      int          seen;
      logic [31:0] exp_data;
      logic        exp_pr, exp_pv;
      int          sz, off;
      seen = 0;
      forever begin
         @(negedge pclk);
         #4;
         if (preset || seen != rst_cnt) begin
            q.delete();
            seen = rst_cnt;
         end
         exp_data = '0;
         for (int k = 0; k < int'(ctrl_size); k++)
            if (int'(ctrl_offset) + k < B && k < q.size())
               exp_data[8*(int'(ctrl_offset)+k) +: 8] = q[k];
         exp_pr = (q.size() <= B) && !clr;
         exp_pv = (q.size() >= int'(ctrl_size));
         chk("model_pop_ready", pop_if.ready, exp_pr);
         chk("model_push_valid", push_if.valid, exp_pv);
         chk("model_push_data", push_if.data, {ctrl_size, ctrl_offset, exp_data});
         chk("model_cnt", status_cnt_bytes, q.size());
         if (!preset) begin
            if (exp_pv && push_if.ready)
               repeat (int'(ctrl_size)) void'(q.pop_front());
            if (clr)
               q.delete();
            else if (pop_if.valid && exp_pr) begin
               sz  = int'(pop_if.data[36:34]);
               off = int'(pop_if.data[33:32]);
               for (int k = 0; k < sz; k++)
                  q.push_back(pop_if.data[8*(off+k) +: 8]);
            end
         end
      end
   end

   initial begin
      pop_if.valid  = 1'b0;
      pop_if.data   = '0;
      push_if.ready = 1'b0;
      repeat (2) @(negedge pclk);
      #1;
      preset = 1'b0;
      #1;
      chk("rst_pop_ready", pop_if.ready, 1'b1);
      chk("rst_push_valid", push_if.valid, 1'b0);
      chk("rst_cnt", status_cnt_bytes, 4'd0);
      chk("rst_push_data", push_if.data, {3'd4, 2'd0, 32'h0});

      // Byte gathering
      push_if.ready = 1'b1;
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd1, 2'd0, 32'h0000_0011);
      tick();
      pop_if.data = ent(3'd1, 2'd1, 32'h0000_2200);
      tick();
      pop_if.data = ent(3'd1, 2'd2, 32'h0033_0000);
      tick();
      pop_if.data = ent(3'd1, 2'd3, 32'h4400_0000);
      #1;
      chk("gather_pv_early", push_if.valid, 1'b0);
      tick();
      pop_if.valid = 1'b0;
      #1;
      chk("gather_pv", push_if.valid, 1'b1);
      chk("gather_data", push_if.data, {3'd4, 2'd0, 32'h4433_2211});
      tick();
      #1;
      chk("gather_one_push", push_if.valid, 1'b0);

      // Splitting
      ctrl_size = 3'd2; ctrl_offset = 2'd2;
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd4, 2'd0, 32'hDDCC_BBAA);
      tick();
      pop_if.valid = 1'b0;
      #1;
      chk("split_first", push_if.data, {3'd2, 2'd2, 32'hBBAA_0000});
      tick();
      #1;
      chk("split_second", push_if.data, {3'd2, 2'd2, 32'hDDCC_0000});
      tick();
      #1;
      chk("split_empty", push_if.valid, 1'b0);

      // Backpressure
      ctrl_size = 3'd4; ctrl_offset = 2'd0; push_if.ready = 1'b0;
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd4, 2'd0, 32'h0302_0100);
      tick();
      pop_if.data = ent(3'd4, 2'd0, 32'h0706_0504);
      tick();
      pop_if.data = ent(3'd4, 2'd0, 32'h0B0A_0908);
      #1;
      chk("bp_pop_ready", pop_if.ready, 1'b0);
      chk("bp_cnt", status_cnt_bytes, 4'd8);
      chk("bp_data", push_if.data, {3'd4, 2'd0, 32'h0302_0100});
      tick();
      #1;
      chk("bp_hold_data", push_if.data, {3'd4, 2'd0, 32'h0302_0100});
      chk("bp_hold_cnt", status_cnt_bytes, 4'd8);
      pop_if.valid = 1'b0; push_if.ready = 1'b1;
      tick();
      #1;
      chk("bp_drain2", push_if.data, {3'd4, 2'd0, 32'h0706_0504});
      tick();
      #1;
      chk("bp_drained", status_cnt_bytes, 4'd0);

      // Simultaneous pop and push
      ctrl_size = 3'd2; push_if.ready = 1'b0;
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd2, 2'd0, 32'h0000_BBAA);
      tick();
      push_if.ready = 1'b1; pop_if.data = ent(3'd2, 2'd2, 32'hDDCC_0000);
      #1;
      chk("sim_cnt_before", status_cnt_bytes, 4'd2);
      chk("sim_data_before", push_if.data, {3'd2, 2'd0, 32'h0000_BBAA});
      tick();
      pop_if.valid = 1'b0; push_if.ready = 1'b0;
      #1;
      chk("sim_cnt_after", status_cnt_bytes, 4'd2);
      chk("sim_data_after", push_if.data, {3'd2, 2'd0, 32'h0000_DDCC});
      push_if.ready = 1'b1;
      tick();
      #1;
      chk("sim_empty", status_cnt_bytes, 4'd0);

      // Full-rate streaming
      ctrl_size = 3'd4;
      for (int i = 0; i < 4; i++) begin
         tick();
         pop_if.valid = 1'b1; pop_if.data = ent(3'd4, 2'd0, 32'h1020_3040 + 32'(i));
         #1;
         chk("tput_pop_ready", pop_if.ready, 1'b1);
      end
      tick();
      pop_if.valid = 1'b0;
      tick();
      #1;
      chk("tput_empty", status_cnt_bytes, 4'd0);

      // Asynchronous reset mid-operation
      push_if.ready = 1'b0;
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd3, 2'd0, 32'h0033_2211);
      tick();
      pop_if.valid = 1'b0;
      #1;
      chk("ar_cnt_before", status_cnt_bytes, 4'd3);
      preset = 1'b1;
      #1;
      chk("ar_cnt", status_cnt_bytes, 4'd0);
      chk("ar_push_valid", push_if.valid, 1'b0);
      chk("ar_pop_ready", pop_if.ready, 1'b1);
      preset = 1'b0;
      rst_cnt++;
      push_if.ready = 1'b1;
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd4, 2'd0, 32'h1234_5678);
      tick();
      pop_if.valid = 1'b0;
      #1;
      chk("ar_clean_word", push_if.data, {3'd4, 2'd0, 32'h1234_5678});

      // Flush
      tick();
      pop_if.valid = 1'b1; pop_if.data = ent(3'd3, 2'd0, 32'h00CC_BBAA);
      tick();
      clr = 1'b1; pop_if.data = ent(3'd1, 2'd3, 32'hEE00_0000);
      #1;
      chk("clr_pop_ready", pop_if.ready, 1'b0);
      chk("clr_cnt_before", status_cnt_bytes, 4'd3);
      tick();
      clr = 1'b0; pop_if.valid = 1'b0;
      #1;
      chk("clr_cnt", status_cnt_bytes, 4'd0);
      chk("clr_push_valid", push_if.valid, 1'b0);
      pop_if.valid = 1'b1; pop_if.data = ent(3'd4, 2'd0, 32'hA1B2_C3D4);
      tick();
      pop_if.valid = 1'b0;
      #1;
      chk("clr_clean_word", push_if.data, {3'd4, 2'd0, 32'hA1B2_C3D4});
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
